// File: rtl/pong_match_ctrl.sv
// Match-level controller for pong: sequences IDLE/SERVE/PLAY/POINT/OVER,
// keeps saturating per-player scores, and picks serve direction and winner.
module pong_match_ctrl #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned SCORE_W      = 4,
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 120
) (
  input  logic                              clk,
  input  logic                              RESET,
  input  logic                              frame_tick,
  input  logic                              start,
  input  logic [NUM_PLAYERS-1:0]            point_in,
  output logic                              ball_run,
  output logic                              ball_recenter,
  output logic [$clog2(NUM_PLAYERS)-1:0]    serve_to,
  output logic [NUM_PLAYERS*SCORE_W-1:0]    scores,
  output logic [2:0]                        state,
  output logic [$clog2(NUM_PLAYERS)-1:0]    winner,
  output logic                              winner_valid
);

  localparam int unsigned PIDX_W = $clog2(NUM_PLAYERS);
  localparam int unsigned MAX_FR = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CNT_W  = $clog2(MAX_FR + 1);
  localparam int unsigned SC_W   = NUM_PLAYERS * SCORE_W;

  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] SCORE_WIN  = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [PIDX_W-1:0]  LAST_IDX   = PIDX_W'(NUM_PLAYERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SC_W-1:0]     r_scores,     w_scores_nxt;
  logic [PIDX_W-1:0]   r_serve_to,   w_serve_nxt;
  logic [PIDX_W-1:0]   r_winner,     w_winner_nxt;
  logic [CNT_W-1:0]    r_cnt,        w_cnt_nxt;
  logic                r_ball_run,   w_ball_run_nxt;
  logic                r_recenter,   w_recenter_nxt;
  logic                r_win_valid,  w_win_valid_nxt;

  logic                w_point;
  logic [PIDX_W-1:0]   w_k;
  logic [SCORE_W-1:0]  w_k_old;
  logic [SCORE_W-1:0]  w_k_score;
  logic [PIDX_W-1:0]   w_serve_k;
  logic                w_win;

  // Point decode: lowest set index wins simultaneous pulses.
  always_comb begin
    w_k     = '0;
    w_k_old = '0;
    for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
      if (point_in[i]) begin
        w_k     = PIDX_W'(i);
        w_k_old = r_scores[i*SCORE_W +: SCORE_W];
      end
    end
    w_point   = |point_in;
    w_k_score = (w_k_old == SCORE_MAX) ? w_k_old : w_k_old + SCORE_W'(1);
    w_serve_k = (w_k == LAST_IDX) ? '0 : w_k + PIDX_W'(1);
    w_win     = (w_k_score == SCORE_WIN);
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_scores    <= '0;
      r_serve_to  <= '0;
      r_winner    <= '0;
      r_cnt       <= '0;
      r_ball_run  <= 1'b0;
      r_recenter  <= 1'b0;
      r_win_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_scores    <= w_scores_nxt;
      r_serve_to  <= w_serve_nxt;
      r_winner    <= w_winner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ball_run  <= w_ball_run_nxt;
      r_recenter  <= w_recenter_nxt;
      r_win_valid <= w_win_valid_nxt;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_OVER: if (start) w_state_nxt = ST_SERVE;
      ST_SERVE: if (frame_tick && (r_cnt == SERVE_LAST)) w_state_nxt = ST_PLAY;
      ST_PLAY:  if (w_point) w_state_nxt = w_win ? ST_OVER : ST_POINT;
      ST_POINT: if (frame_tick && (r_cnt == POINT_LAST)) w_state_nxt = ST_SERVE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and output next values, derived from the current and next state.
  always_comb begin
    w_scores_nxt = r_scores;
    w_serve_nxt  = r_serve_to;
    w_winner_nxt = r_winner;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          w_scores_nxt = '0;
          w_serve_nxt  = '0;
          w_cnt_nxt    = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) w_cnt_nxt = (r_cnt == SERVE_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
      ST_PLAY: begin
        if (w_point) begin
          for (int i = 0; i < int'(NUM_PLAYERS); i++) begin
            if (PIDX_W'(i) == w_k) w_scores_nxt[i*SCORE_W +: SCORE_W] = w_k_score;
          end
          w_serve_nxt = w_serve_k;
          w_cnt_nxt   = '0;
          if (w_win) w_winner_nxt = w_k;
        end
      end
      ST_POINT: begin
        if (frame_tick) w_cnt_nxt = (r_cnt == POINT_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
      default: w_cnt_nxt = '0;
    endcase
    w_ball_run_nxt  = (w_state_nxt == ST_PLAY);
    w_recenter_nxt  = (w_state_nxt == ST_SERVE) && (r_state != ST_SERVE);
    w_win_valid_nxt = (w_state_nxt == ST_OVER);
  end

  assign state         = r_state;
  assign scores        = r_scores;
  assign serve_to      = r_serve_to;
  assign winner        = r_winner;
  assign ball_run      = r_ball_run;
  assign ball_recenter = r_recenter;
  assign winner_valid  = r_win_valid;

endmodule
